// File: rtl/sat_pkg.sv
// sat_pkg: shared types and constants for the SAT search controller.
// Holds the FSM state enum, LFSR tap polynomial, default seed and LFSR step.
package sat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_EVAL = 2'd2
  } state_t;

  // Galois form of x^32 + x^22 + x^2 + x + 1 (right-shifting register).
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] SAT_SEED  = 32'hACE1_0001;

  function automatic logic [31:0] lfsr_step(
    input logic [31:0] s
  );
    logic [31:0] n;
    n = {1'b0, s[31:1]};
    if (s[0]) n = n ^ LFSR_TAPS;
    return n;
  endfunction

endpackage

// File: rtl/sat_search_ctrl_if.sv
// sat_search_ctrl_if: control/result bundle between the search controller
// and its host plus clause array. master = host side, slave = controller.
interface sat_search_ctrl_if #(
  parameter int unsigned N         = 3,
  parameter int unsigned MAX_FLIPS = 8,
  parameter int unsigned MAX_TRIES = 4
);
  localparam int FW = $clog2(MAX_FLIPS + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);

  logic          start;
  logic          abort;
  logic          sat_in;
  logic [N-1:0]  assignment;
  logic          busy;
  logic          done;
  logic          found;
  logic [FW-1:0] flips;
  logic [TW-1:0] tries;

  modport master (
    output start, abort, sat_in,
    input  assignment, busy, done, found,
    input  flips, tries
  );

  modport slave (
    input  start, abort, sat_in,
    output assignment, busy, done, found,
    output flips, tries
  );

endinterface

// File: rtl/sat_lfsr32.sv
// sat_lfsr32: free-running 32-bit Galois LFSR, advances every clock.
// Ports: clk, reset (sync, active-low, reloads SEED), rnd[31:0] state.
module sat_lfsr32
  import sat_pkg::*;
#(
  parameter logic [31:0] SEED = SAT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rnd
);

  logic [31:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  assign rnd = r_lfsr;

endmodule

// File: rtl/sat_search_ctrl.sv
// sat_search_ctrl: WalkSAT-style random-flip search controller.
// Ports: clk, reset (sync active-low), bus (slave): start/abort/sat_in in;
// assignment/busy/done/found/flips/tries out. Restarts: SAT_SEARCH_RESTART_EN.
module sat_search_ctrl
  import sat_pkg::*;
#(
  parameter int unsigned N         = 3,
  parameter int unsigned MAX_FLIPS = 8,
  parameter int unsigned MAX_TRIES = 4,
  parameter logic [31:0] SEED      = SAT_SEED
) (
  input  logic clk,
  input  logic reset,
  sat_search_ctrl_if.slave bus
);

  localparam int FW = $clog2(MAX_FLIPS + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [FW-1:0] FLIP_LIM = FW'(MAX_FLIPS);
  localparam logic [TW-1:0] TRY_LIM  = TW'(MAX_TRIES);
  localparam logic [TW-1:0] TRY_ONE  = TW'(1);

  generate
    if (N < 1 || N > 32) begin : g_bad_n
      $error("N out of range 1..32");
    end
    if (MAX_FLIPS < 1) begin : g_bad_f
      $error("MAX_FLIPS must be >= 1");
    end
    if (MAX_TRIES < 1) begin : g_bad_t
      $error("MAX_TRIES must be >= 1");
    end
    if (SEED == 32'd0) begin : g_bad_s
      $error("SEED must be nonzero");
    end
  endgenerate

  logic [31:0]   w_rnd;
  logic [IW-1:0] w_idx;
  logic [N-1:0]  w_mask;

  state_t        r_state;
  logic [N-1:0]  r_asg;
  logic          r_busy;
  logic          r_done;
  logic          r_found;
  logic [FW-1:0] r_flips;
  logic [TW-1:0] r_tries;

  sat_lfsr32 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .rnd   (w_rnd)
  );

  // Flip target taken from the live LFSR value.
  assign w_idx  = IW'(w_rnd % N);
  assign w_mask = N'(1) << w_idx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_asg   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_found <= 1'b0;
      r_flips <= '0;
      r_tries <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_busy  <= 1'b1;
            r_found <= 1'b0;
            r_tries <= TRY_ONE;
            r_state <= ST_INIT;
          end
        end
        ST_INIT: begin
          if (bus.abort) begin
            r_done  <= 1'b1;
            r_found <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_asg   <= w_rnd[N-1:0];
            r_flips <= '0;
            r_state <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (bus.abort) begin
            r_done  <= 1'b1;
            r_found <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (bus.sat_in) begin
            r_done  <= 1'b1;
            r_found <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_flips < FLIP_LIM) begin
            r_asg   <= r_asg ^ w_mask;
            r_flips <= r_flips + FW'(1);
          end else begin
`ifdef SAT_SEARCH_RESTART_EN
            if (r_tries < TRY_LIM) begin
              r_tries <= r_tries + TRY_ONE;
              r_state <= ST_INIT;
            end else begin
              r_done  <= 1'b1;
              r_found <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
`else
            r_done  <= 1'b1;
            r_found <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
`endif
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.assignment = r_asg;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.found      = r_found;
  assign bus.flips      = r_flips;
  assign bus.tries      = r_tries;

endmodule

// File: tb/tb_sat_search_ctrl.sv
// tb_sat_search_ctrl: directed bench for sat_search_ctrl with a search
// predictor feeding a result scoreboard.
module tb_sat_search_ctrl;

  localparam int unsigned N  = 3;
  localparam int unsigned MF = 8;
  localparam int unsigned MT = 4;
  localparam logic [31:0] SEED = 32'hACE1_0001;
  localparam logic [31:0] POLY = 32'h8020_0003;

`ifdef SAT_SEARCH_RESTART_EN
  localparam int EXP_TRIES = MT;
  localparam int EXTRA = 31;
`else
  localparam int EXP_TRIES = 1;
  localparam int EXTRA = 1;
`endif

  typedef struct {
    logic       found;
    int         flips;
    int         tries;
    logic [2:0] asg;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   sat_mode = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [31:0] m_lfsr = SEED;
  logic [31:0] m_prev = SEED;

  exp_t sb[$];

  sat_search_ctrl_if #(.N(N), .MAX_FLIPS(MF), .MAX_TRIES(MT)) bus ();

  sat_search_ctrl #(
    .N(N), .MAX_FLIPS(MF), .MAX_TRIES(MT), .SEED(SEED)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.sat_in = (sat_mode == 1) ? 1'b1 :
                      (sat_mode == 2) ? (bus.assignment == 3'b101) :
                      1'b0;

  function automatic logic [31:0] adv(input logic [31:0] s);
    return s[0] ? ({1'b0, s[31:1]} ^ POLY) : {1'b0, s[31:1]};
  endfunction

  always @(posedge clk) begin
    m_prev <= m_lfsr;
    m_lfsr <= reset ? adv(m_lfsr) : SEED;
  end

  // Walks the search edge by edge from the LFSR value seen at the start edge.
  function automatic exp_t predict(input logic [31:0] s, input int mode);
    exp_t e;
    logic [31:0] r;
    logic [2:0] a, m;
    int f, t, c, ph;
    bit fin, sat;
    r = adv(s);
    a = 3'd0; f = 0; t = 1; c = 1; ph = 0; fin = 0;
    e.found = 1'b0;
    for (int g = 0; g < 2000 && !fin; g++) begin
      c++;
      if (ph == 0) begin
        a = r[2:0]; f = 0; ph = 1;
      end else begin
        sat = (mode == 1) || (mode == 2 && a == 3'b101);
        if (sat) begin
          fin = 1; e.found = 1'b1;
        end else if (f < int'(MF)) begin
          m = 3'b001 << (r % 32'd3);
          a = a ^ m; f++;
        end else begin
`ifdef SAT_SEARCH_RESTART_EN
          if (t < int'(MT)) begin t++; ph = 0; end
          else fin = 1;
`else
          fin = 1;
`endif
        end
      end
      r = adv(r);
    end
    e.flips = f; e.tries = t; e.asg = a; e.cyc = c;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic run_search(input int mode, input string tag,
                            output int cyc);
    exp_t e, g;
    int n;
    bit seen;
    sat_mode = mode;
    e = predict(m_lfsr, mode);
    sb.push_back(e);
    bus.start = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 300) begin
      step();
      bus.start = 1'b0;
      n++;
      if (bus.done === 1'b1) seen = 1;
    end
    chk({tag, "_done"}, 64'(seen), 64'd1);
    g = sb.pop_front();
    if (seen) begin
      chk({tag, "_found"}, 64'(bus.found), 64'(g.found));
      chk({tag, "_flips"}, 64'(bus.flips), 64'(g.flips));
      chk({tag, "_tries"}, 64'(bus.tries), 64'(g.tries));
      chk({tag, "_asg"}, 64'(bus.assignment), 64'(g.asg));
      chk({tag, "_cyc"}, 64'(n), 64'(g.cyc));
    end
    cyc = n;
  endtask

  initial begin
    logic [2:0] pa, mk;
    int c1, c2, k;
    bus.start = 1'b0;
    bus.abort = 1'b0;

    // reset state
    reset = 1'b0;
    step();
    step();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_found", 64'(bus.found), 64'd0);
    chk("rst_flips", 64'(bus.flips), 64'd0);
    chk("rst_tries", 64'(bus.tries), 64'd0);
    chk("rst_asg", 64'(bus.assignment), 64'd0);
    reset = 1'b1;
    step();

    // sat_in tied high: INIT then immediate hit
    sat_mode = 1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("t0_busy", 64'(bus.busy), 64'd1);
    chk("t0_tries", 64'(bus.tries), 64'd1);
    chk("t0_done", 64'(bus.done), 64'd0);
    step();
    chk("t1_asg", 64'(bus.assignment), 64'(m_prev[2:0]));
    chk("t1_done", 64'(bus.done), 64'd0);
    step();
    chk("t2_done", 64'(bus.done), 64'd1);
    chk("t2_found", 64'(bus.found), 64'd1);
    chk("t2_busy", 64'(bus.busy), 64'd0);
    chk("t2_flips", 64'(bus.flips), 64'd0);
    step();
    chk("t3_done", 64'(bus.done), 64'd0);
    chk("t3_found", 64'(bus.found), 64'd1);

    // sat_in tied low: single-bit flips until exhaustion
    sat_mode = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("ex_found_clr", 64'(bus.found), 64'd0);
    step();
    chk("ex_init_asg", 64'(bus.assignment), 64'(m_prev[2:0]));
    chk("ex_init_flips", 64'(bus.flips), 64'd0);
    for (int i = 1; i <= int'(MF); i++) begin
      pa = bus.assignment;
      step();
      mk = 3'b001 << (m_prev % 32'd3);
      chk($sformatf("ex_flip%0d_asg", i), 64'(bus.assignment),
          64'(pa ^ mk));
      chk($sformatf("ex_flip%0d_cnt", i), 64'(bus.flips), 64'(i));
    end
    k = 0;
    while (bus.done !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    chk("ex_done_lat", 64'(k), 64'(EXTRA));
    chk("ex_found", 64'(bus.found), 64'd0);
    chk("ex_flips_sat", 64'(bus.flips), 64'(MF));
    chk("ex_tries", 64'(bus.tries), 64'(EXP_TRIES));
    step();

    // abort in IDLE is a no-op
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("idle_abort_done", 64'(bus.done), 64'd0);
    chk("idle_abort_busy", 64'(bus.busy), 64'd0);

    // start during busy ignored; abort outranks sat_in
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    chk("busy_flips1", 64'(bus.flips), 64'd1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("busy_start_flips", 64'(bus.flips), 64'd2);
    chk("busy_start_tries", 64'(bus.tries), 64'd1);
    sat_mode = 1;
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_done", 64'(bus.done), 64'd1);
    chk("abort_found", 64'(bus.found), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    step();

    // reset mid-EVAL: everything clears, no done pulse
    sat_mode = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    step();
    sat_mode = 1;
    reset = 1'b0;
    step();
    chk("mrst_busy", 64'(bus.busy), 64'd0);
    chk("mrst_done", 64'(bus.done), 64'd0);
    chk("mrst_asg", 64'(bus.assignment), 64'd0);
    chk("mrst_flips", 64'(bus.flips), 64'd0);
    chk("mrst_tries", 64'(bus.tries), 64'd0);
    reset = 1'b1;
    step();
    chk("mrst_done2", 64'(bus.done), 64'd0);

    // scoreboarded searches
    run_search(1, "sb_hit", c1);
    step();
    run_search(0, "sb_miss", c1);
    step();

    // model hit on 3'b101, repeated after reset for determinism
    do_reset();
    run_search(2, "m101_a", c1);
    do_reset();
    run_search(2, "m101_b", c2);
    chk("m101_repeat", 64'(c2), 64'(c1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
